// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl
//   Multi-row sequencer for the three-pass softmax datapath. A latched
//   command walks num_rows rows (base advancing by row_stride) through a
//   max pass, a subtract/exp/accumulate pass, an ln step and an output
//   pass. Datapath strobes are registered delay lines of the read strobe,
//   so they line up with the configured unit latencies.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start, abort        command strobe (taken only when idle), flush
//   start_addr/end_addr first/last word of row 0
//   row_stride          base increment between rows
//   num_rows            rows per command (0 is rejected)
//   busy, done, err     handshake: busy level, completion/reject pulses
//   rd_en, rd_addr      memory read strobe and address
//   phase               0 idle, 1 max, 2 sum, 3 out
//   max_vld/max_first   read data valid into the max tree, first of row
//   acc_vld/acc_first   exp data valid into the accumulator, first of row
//   ln_start            sum is final, start the ln unit
//   wr_en, wr_addr      output write strobe and address
//   row_done, row_idx   end-of-row pulse and index of the current row

module softmax_seq_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int ROW_W   = 8,
    parameter int RD_LAT  = 1,
    parameter int MAX_LAT = 2,
    parameter int EXP_LAT = 2,
    parameter int ADD_LAT = 1,
    parameter int LN_LAT  = 3,
    parameter int OUT_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [ROW_W-1:0]  num_rows,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        phase,
    output logic              max_vld,
    output logic              max_first,
    output logic              acc_vld,
    output logic              acc_first,
    output logic              ln_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              row_done,
    output logic [ROW_W-1:0]  row_idx
);

    localparam int MAX_DR_N = RD_LAT + MAX_LAT;
    localparam int SUM_DR_N = RD_LAT + EXP_LAT + ADD_LAT;
    localparam int OUT_DR_N = RD_LAT + OUT_LAT;
    localparam int ACC_D    = RD_LAT + EXP_LAT;
    localparam int CNT_W    = (ADDR_W > 8) ? ADDR_W : 8;

    typedef enum logic [2:0] {
        S_IDLE, S_MAX, S_MAX_DR, S_SUM, S_SUM_DR, S_LN, S_OUT, S_OUT_DR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  len_m1_q, len_m1_d;
    logic [ADDR_W-1:0]  stride_q, stride_d;
    logic [ROW_W-1:0]   num_rows_q, num_rows_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]   row_idx_q, row_idx_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               row_done_q, row_done_d;
    logic               last_rd;
    logic               flush;

    assign busy    = (state_q != S_IDLE);
    assign flush   = reset || (abort && busy);
    // cnt only runs over 0..L-1 in the read states
    assign last_rd = (cnt_q == CNT_W'(len_m1_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        base_d     = base_q;
        len_m1_d   = len_m1_q;
        stride_d   = stride_q;
        num_rows_d = num_rows_q;
        row_cnt_d  = row_cnt_q;
        row_idx_d  = row_idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        row_done_d = 1'b0;
        // row_idx keeps naming the finished row during its row_done pulse
        // and moves on one cycle later, only if another row is running.
        if (row_done_q && busy) begin
            row_idx_d = row_idx_q + ROW_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    base_d     = start_addr;
                    len_m1_d   = end_addr - start_addr;
                    stride_d   = row_stride;
                    num_rows_d = num_rows;
                    row_cnt_d  = '0;
                    row_idx_d  = '0;
                    if ((end_addr < start_addr) || (num_rows == '0)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_MAX;
                    end
                end
            end
            S_MAX: begin
                if (last_rd) begin
                    state_d = S_MAX_DR;
                    cnt_d   = '0;
                end
            end
            S_MAX_DR: begin
                if (cnt_q == CNT_W'(MAX_DR_N - 1)) begin
                    state_d = S_SUM;
                    cnt_d   = '0;
                end
            end
            S_SUM: begin
                if (last_rd) begin
                    state_d = S_SUM_DR;
                    cnt_d   = '0;
                end
            end
            S_SUM_DR: begin
                if (cnt_q == CNT_W'(SUM_DR_N - 1)) begin
                    state_d = S_LN;
                    cnt_d   = '0;
                end
            end
            S_LN: begin
                if (cnt_q == CNT_W'(LN_LAT - 1)) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end
            end
            S_OUT: begin
                if (last_rd) begin
                    state_d = S_OUT_DR;
                    cnt_d   = '0;
                end
            end
            S_OUT_DR: begin
                if (cnt_q == CNT_W'(OUT_DR_N - 1)) begin
                    row_done_d = 1'b1;
                    cnt_d      = '0;
                    if (row_cnt_q == num_rows_q - ROW_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                        base_d    = base_q + stride_q;
                        state_d   = S_MAX;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // abort only matters while a command runs; in idle start wins
        if (abort && busy) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            base_d     = base_q;
            row_cnt_d  = row_cnt_q;
            row_idx_d  = row_idx_q;
            done_d     = 1'b0;
            err_d      = 1'b0;
            row_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            base_q     <= '0;
            len_m1_q   <= '0;
            stride_q   <= '0;
            num_rows_q <= '0;
            row_cnt_q  <= '0;
            row_idx_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            row_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            len_m1_q   <= len_m1_d;
            stride_q   <= stride_d;
            num_rows_q <= num_rows_d;
            row_cnt_q  <= row_cnt_d;
            row_idx_q  <= row_idx_d;
            done_q     <= done_d;
            err_q      <= err_d;
            row_done_q <= row_done_d;
        end
    end

    // ---- read-side stage: strobes decoded from the registered state ----
    logic rd_max, rd_sum, rd_out, rd_first;

    assign rd_max   = (state_q == S_MAX);
    assign rd_sum   = (state_q == S_SUM);
    assign rd_out   = (state_q == S_OUT);
    assign rd_en    = rd_max || rd_sum || rd_out;
    assign rd_first = rd_en && (cnt_q == '0);
    assign rd_addr  = rd_en ? (base_q + cnt_q[ADDR_W-1:0]) : '0;
    assign ln_start = (state_q == S_LN) && (cnt_q == '0);

    always_comb begin
        case (state_q)
            S_MAX, S_MAX_DR:      phase = 2'd1;
            S_SUM, S_SUM_DR:      phase = 2'd2;
            S_LN, S_OUT, S_OUT_DR: phase = 2'd3;
            default:              phase = 2'd0;
        endcase
    end

    // ---- datapath-aligned stage: delay lines of the read strobe ----
    logic              max_vld_p   [RD_LAT];
    logic              max_first_p [RD_LAT];
    logic              acc_vld_p   [ACC_D];
    logic              acc_first_p [ACC_D];
    logic              wr_en_p     [OUT_DR_N];
    logic [ADDR_W-1:0] wr_addr_p   [OUT_DR_N];

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < RD_LAT; i++) begin
                max_vld_p[i]   <= 1'b0;
                max_first_p[i] <= 1'b0;
            end
            for (int i = 0; i < ACC_D; i++) begin
                acc_vld_p[i]   <= 1'b0;
                acc_first_p[i] <= 1'b0;
            end
            for (int i = 0; i < OUT_DR_N; i++) begin
                wr_en_p[i]   <= 1'b0;
                wr_addr_p[i] <= '0;
            end
        end else begin
            max_vld_p[0]   <= rd_max;
            max_first_p[0] <= rd_max && rd_first;
            for (int i = 1; i < RD_LAT; i++) begin
                max_vld_p[i]   <= max_vld_p[i-1];
                max_first_p[i] <= max_first_p[i-1];
            end
            acc_vld_p[0]   <= rd_sum;
            acc_first_p[0] <= rd_sum && rd_first;
            for (int i = 1; i < ACC_D; i++) begin
                acc_vld_p[i]   <= acc_vld_p[i-1];
                acc_first_p[i] <= acc_first_p[i-1];
            end
            wr_en_p[0]   <= rd_out;
            wr_addr_p[0] <= rd_addr;
            for (int i = 1; i < OUT_DR_N; i++) begin
                wr_en_p[i]   <= wr_en_p[i-1];
                wr_addr_p[i] <= wr_addr_p[i-1];
            end
        end
    end

    assign max_vld   = max_vld_p[RD_LAT-1];
    assign max_first = max_first_p[RD_LAT-1];
    assign acc_vld   = acc_vld_p[ACC_D-1];
    assign acc_first = acc_first_p[ACC_D-1];
    assign wr_en     = wr_en_p[OUT_DR_N-1];
    assign wr_addr   = wr_addr_p[OUT_DR_N-1];
    assign done      = done_q;
    assign err       = err_q;
    assign row_done  = row_done_q;
    assign row_idx   = row_idx_q;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb_softmax_seq_ctrl
//   Drives directed and randomized commands into softmax_seq_ctrl and
//   compares every cycle against an expected timeline built from the
//   row schedule (reads, drains, ln step, delayed strobes, pulses).

module tb_softmax_seq_ctrl;

    localparam int ADDR_W = 10;
    localparam int ROW_W  = 8;
    localparam int RD = 1, MX = 2, EX = 2, AD = 1, LN = 3, OU = 4;
    localparam int W = 1024;

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic [ADDR_W-1:0] start_addr, end_addr, row_stride;
    logic [ROW_W-1:0]  num_rows;
    logic              busy, done, err, rd_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [1:0]        phase;
    logic              max_vld, max_first, acc_vld, acc_first, ln_start;
    logic              wr_en, row_done;
    logic [ROW_W-1:0]  row_idx;

    softmax_seq_ctrl #(
        .ADDR_W(ADDR_W), .ROW_W(ROW_W), .RD_LAT(RD), .MAX_LAT(MX),
        .EXP_LAT(EX), .ADD_LAT(AD), .LN_LAT(LN), .OUT_LAT(OU)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .row_stride(row_stride), .num_rows(num_rows),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .rd_addr(rd_addr), .phase(phase), .max_vld(max_vld),
        .max_first(max_first), .acc_vld(acc_vld), .acc_first(acc_first),
        .ln_start(ln_start), .wr_en(wr_en), .wr_addr(wr_addr),
        .row_done(row_done), .row_idx(row_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected timeline, indexed by cycle relative to scenario start
    bit e_busy [W], e_done [W], e_err [W], e_rd [W];
    bit e_mv [W], e_mf [W], e_av [W], e_af [W], e_ln [W], e_wr [W], e_rdn [W];
    int e_rda [W], e_ph [W], e_wra [W], e_ridx [W];

    typedef struct {
        int t;
        int kind;   // 0 start, 1 abort, 2 reset
        int sa, ea, st, nr;
    } ev_t;
    ev_t evq[$];

    task automatic clr_from(input int t0);
        for (int t = t0; t < W; t++) begin
            e_busy[t] = 0; e_done[t] = 0; e_err[t] = 0; e_rd[t] = 0;
            e_mv[t] = 0; e_mf[t] = 0; e_av[t] = 0; e_af[t] = 0;
            e_ln[t] = 0; e_wr[t] = 0; e_rdn[t] = 0;
            e_rda[t] = 0; e_ph[t] = 0; e_wra[t] = 0; e_ridx[t] = 0;
        end
    endtask

    task automatic put_rd(input int t, input int a, input int p);
        e_rd[t] = 1; e_rda[t] = a; e_ph[t] = p;
    endtask

    task automatic add_cmd(input int t0, input int sa, input int ea, input int st, input int nr);
        int len, d1, d2, d3, rl, s, base, a, t2, t3;
        if (ea < sa || nr == 0) begin
            e_done[t0+1] = 1; e_err[t0+1] = 1;
            return;
        end
        len = ea - sa + 1;
        d1 = RD + MX; d2 = RD + EX + AD; d3 = RD + OU;
        rl = 3*len + d1 + d2 + LN + d3;
        for (int r = 0; r < nr; r++) begin
            s = t0 + 1 + r*rl;
            base = (sa + r*st) % 1024;
            for (int t = s; t < s + rl; t++) e_busy[t] = 1;
            for (int k = 0; k < len; k++) begin
                a = (base + k) % 1024;
                put_rd(s + k, a, 1);
                e_mv[s+k+RD] = 1;
                if (k == 0) e_mf[s+k+RD] = 1;
                t2 = s + len + d1 + k;
                put_rd(t2, a, 2);
                e_av[t2+RD+EX] = 1;
                if (k == 0) e_af[t2+RD+EX] = 1;
                t3 = s + 2*len + d1 + d2 + LN + k;
                put_rd(t3, a, 3);
                e_wr[t3+RD+OU] = 1; e_wra[t3+RD+OU] = a;
            end
            e_ln[s + 2*len + d1 + d2] = 1;
            e_rdn[s+rl] = 1; e_ridx[s+rl] = r;
        end
        e_done[t0 + 1 + nr*rl] = 1;
    endtask

    function automatic logic [63:0] pack_got();
        return {31'b0, busy, done, err, rd_en, (rd_en ? rd_addr : 10'd0),
                (rd_en ? phase : 2'd0), max_vld, max_first, acc_vld, acc_first,
                ln_start, wr_en, (wr_en ? wr_addr : 10'd0), row_done};
    endfunction

    function automatic logic [63:0] pack_exp(input int c);
        logic [9:0] ra, wa;
        logic [1:0] ph;
        ra = 10'(e_rda[c]); wa = 10'(e_wra[c]); ph = 2'(e_ph[c]);
        return {31'b0, e_busy[c], e_done[c], e_err[c], e_rd[c], ra, ph,
                e_mv[c], e_mf[c], e_av[c], e_af[c], e_ln[c], e_wr[c], wa, e_rdn[c]};
    endfunction

    task automatic push(input int t, input int kind, input int sa, input int ea,
                        input int st, input int nr);
        ev_t e;
        e.t = t; e.kind = kind; e.sa = sa; e.ea = ea; e.st = st; e.nr = nr;
        evq.push_back(e);
    endtask

    // events must be pushed in time order
    task automatic run_scn(input string name);
        int last;
        clr_from(0);
        last = 0;
        foreach (evq[i]) begin
            if (evq[i].t > last) last = evq[i].t;
            case (evq[i].kind)
                0: if (!e_busy[evq[i].t])
                       add_cmd(evq[i].t, evq[i].sa, evq[i].ea, evq[i].st, evq[i].nr);
                1: if (e_busy[evq[i].t]) clr_from(evq[i].t + 1);
                default: clr_from(evq[i].t + 1);
            endcase
        end
        for (int t = 0; t < W - 8; t++)
            if (pack_exp(t) != 64'd0) last = t;
        for (int c = 0; c <= last + 4; c++) begin
            start = 1'b0; abort = 1'b0; reset = 1'b0;
            foreach (evq[i]) begin
                if (evq[i].t == c) begin
                    case (evq[i].kind)
                        0: begin
                            start = 1'b1;
                            start_addr = 10'(evq[i].sa);
                            end_addr   = 10'(evq[i].ea);
                            row_stride = 10'(evq[i].st);
                            num_rows   = 8'(evq[i].nr);
                        end
                        1: abort = 1'b1;
                        default: reset = 1'b1;
                    endcase
                end
            end
            @(negedge clk);
            chk($sformatf("%s c%0d", name, c), pack_got(), pack_exp(c));
            if (e_rdn[c]) chk($sformatf("%s row_idx c%0d", name, c), 64'(row_idx), 64'(e_ridx[c]));
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        evq.delete();
    endtask

    initial begin
        int sa, ea, len, st, nr, ta, te;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        start_addr = '0; end_addr = '0; row_stride = '0; num_rows = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("reset outputs", pack_got() | 64'(phase) << 40, 64'd0);
            chk("reset row_idx", 64'(row_idx), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        push(0, 0, 'h10, 'h13, 0, 1);
        run_scn("single");

        push(0, 0, 'h10, 'h11, 'h20, 3);
        run_scn("three_rows");

        push(0, 0, 'h20, 'h10, 0, 1);
        run_scn("end_lt_start");

        push(0, 0, 'h10, 'h13, 0, 0);
        run_scn("zero_rows");

        push(0, 0, 'h10, 'h13, 0, 1);
        push(9, 1, 0, 0, 0, 0);
        push(12, 0, 'h10, 'h13, 0, 1);
        run_scn("abort_restart");

        push(0, 0, 'h3FE, 'h3FF, 3, 2);
        run_scn("wrap");

        push(0, 0, 'h10, 'h13, 0, 1);
        push(10, 0, 'h100, 'h101, 0, 2);
        push(28, 0, 'h40, 'h42, 0, 1);
        run_scn("start_in_done");

        push(0, 0, 'h10, 'h13, 0, 1);
        push(6, 2, 0, 0, 0, 0);
        run_scn("reset_mid");

        push(0, 0, 'h05, 'h06, 0, 1);
        push(0, 1, 0, 0, 0, 0);
        run_scn("start_abort_idle");

        for (int n = 0; n < 25; n++) begin
            sa  = $urandom_range(0, 1023);
            len = $urandom_range(1, 6);
            ea  = (sa + len - 1) % 1024;
            if ($urandom_range(0, 9) == 0 && sa > 0) ea = $urandom_range(0, sa - 1);
            st  = $urandom_range(0, 1023);
            nr  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            te  = $urandom_range(2, 90);
            ta  = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 60) : -1;
            push(0, 0, sa, ea, st, nr);
            if (ta >= 0 && ta < te) push(ta, 1, 0, 0, 0, 0);
            sa = $urandom_range(0, 1000);
            push(te, 0, sa, sa + $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(1, 2));
            if (ta >= te) push(ta, 1, 0, 0, 0, 0);
            run_scn($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
